// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
package ps2_pkg;

    localparam int unsigned PS2_DATA_BITS  = 8;
    localparam int unsigned PS2_FRAME_BITS = 11;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
        ST_PARITY = 2'd2,
        ST_STOP   = 2'd3
    } ps2_state_e;

    typedef logic [PS2_DATA_BITS-1:0] ps2_byte_t;

    // Deframer-to-FIFO push request.
    typedef struct packed {
        logic      valid;
        ps2_byte_t data;
    } ps2_push_t;

    // Odd parity: data bits plus parity bit must hold an odd number of ones.
    function automatic logic odd_parity_ok(input ps2_byte_t d, input logic p);
        return ^{d, p};
    endfunction

endpackage

// File: rtl/ps2_sync_filt.sv
// Pin synchroniser and run-length glitch filter for PS2Clk/PS2Data.
// Emits a one-cycle strobe on each filtered clock falling edge.
module ps2_sync_filt #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_LEN    = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic ps2_clk_i,
    input  logic ps2_data_i,
    output logic fall_strobe_o,
    output logic data_s_o
);

    localparam int unsigned CNT_W = $clog2(FILT_LEN + 1);

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic [1:0]             raw_s;
    logic [1:0]             filt_q, filt_d;
    logic [1:0][CNT_W-1:0]  cnt_q, cnt_d;
    logic                   strobe_q, strobe_d;

    // Index 0 is the clock line, index 1 the data line.
    assign raw_s = {data_sync_q[SYNC_STAGES-1], clk_sync_q[SYNC_STAGES-1]};

    always_comb begin
        filt_d = filt_q;
        cnt_d  = '0;
        for (int i = 0; i < 2; i++) begin
            if (raw_s[i] != filt_q[i]) begin
                if (cnt_q[i] == CNT_W'(FILT_LEN - 1)) begin
                    filt_d[i] = raw_s[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end
        end
        strobe_d = filt_q[0] & ~filt_d[0];
    end

    // Preset to the idle-high bus level so release from reset never looks like an edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            clk_sync_q  <= '1;
            data_sync_q <= '1;
            filt_q      <= '1;
            cnt_q       <= '0;
            strobe_q    <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk_i};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], ps2_data_i};
            filt_q      <= filt_d;
            cnt_q       <= cnt_d;
            strobe_q    <= strobe_d;
        end
    end

    assign fall_strobe_o = strobe_q;
    assign data_s_o      = filt_q[1];

endmodule

// File: rtl/ps2_rx_fifo.sv
// PS/2 device-to-host receiver: deframes 11-bit frames, checks parity/stop,
// enforces an inter-edge timeout and buffers good bytes in a show-ahead FIFO.
module ps2_rx_fifo
    import ps2_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned FILT_LEN    = 8,
    parameter int unsigned TIMEOUT_CYC = 20000,
    parameter int unsigned FIFO_DEPTH  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          PS2Clk,
    input  logic                          PS2Data,
    output logic [7:0]                    c_data,
    output logic                          c_valid,
    input  logic                          c_ready,
    output logic                          parity_err,
    output logic                          frame_err,
    output logic                          overflow,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned TMO_W = $clog2(TIMEOUT_CYC + 1);
    localparam int unsigned BIT_W = $clog2(PS2_DATA_BITS);

    logic strobe;
    logic data_s;

    ps2_sync_filt #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILT_LEN    (FILT_LEN)
    ) u_sync_filt (
        .clk           (clk),
        .rst           (rst),
        .ps2_clk_i     (PS2Clk),
        .ps2_data_i    (PS2Data),
        .fall_strobe_o (strobe),
        .data_s_o      (data_s)
    );

    ps2_state_e         state_q, state_d;
    logic [BIT_W-1:0]   bitcnt_q, bitcnt_d;
    ps2_byte_t          sreg_q, sreg_d;
    logic               par_q, par_d;
    logic [TMO_W-1:0]   tmo_q, tmo_d;
    ps2_push_t          push_q, push_d;
    logic               perr_q, perr_d;
    logic               ferr_q, ferr_d;

    // Deframer: advances on bit strobes; the timeout abandons a stalled frame.
    always_comb begin
        state_d  = state_q;
        bitcnt_d = bitcnt_q;
        sreg_d   = sreg_q;
        par_d    = par_q;
        tmo_d    = (state_q == ST_IDLE) ? '0 : tmo_q + TMO_W'(1);
        push_d   = '{valid: 1'b0, data: sreg_q};
        perr_d   = 1'b0;
        ferr_d   = 1'b0;
        if (strobe) begin
            tmo_d = '0;
            case (state_q)
                ST_IDLE: begin
                    if (!data_s) begin
                        state_d  = ST_DATA;
                        bitcnt_d = '0;
                    end
                end
                ST_DATA: begin
                    sreg_d   = {data_s, sreg_q[PS2_DATA_BITS-1:1]};
                    bitcnt_d = bitcnt_q + BIT_W'(1);
                    if (bitcnt_q == BIT_W'(PS2_DATA_BITS - 1)) begin
                        state_d = ST_PARITY;
                    end
                end
                ST_PARITY: begin
                    par_d   = data_s;
                    state_d = ST_STOP;
                end
                ST_STOP: begin
                    state_d = ST_IDLE;
                    if (!data_s) begin
                        ferr_d = 1'b1;
                    end else if (!odd_parity_ok(sreg_q, par_q)) begin
                        perr_d = 1'b1;
                    end else begin
                        push_d.valid = 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end else if (state_q != ST_IDLE && tmo_q == TMO_W'(TIMEOUT_CYC - 1)) begin
            state_d = ST_IDLE;
            ferr_d  = 1'b1;
            tmo_d   = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            bitcnt_q <= '0;
            sreg_q   <= '0;
            par_q    <= 1'b0;
            tmo_q    <= '0;
            push_q   <= '0;
            perr_q   <= 1'b0;
            ferr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            bitcnt_q <= bitcnt_d;
            sreg_q   <= sreg_d;
            par_q    <= par_d;
            tmo_q    <= tmo_d;
            push_q   <= push_d;
            perr_q   <= perr_d;
            ferr_q   <= ferr_d;
        end
    end

    ps2_byte_t         mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    ps2_byte_t         head_q, head_d;
    logic              valid_q;
    logic              pop, full, do_push;

    assign pop     = valid_q & c_ready;
    assign full    = (count_q == CNT_W'(FIFO_DEPTH));
    assign do_push = push_q.valid & (~full | pop);

    // Next head is computed ahead so the show-ahead outputs come straight from flops;
    // a push landing on the new read slot must bypass the memory.
    always_comb begin
        wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
        rd_ptr_d = rd_ptr_q + PTR_W'(pop);
        count_d  = count_q + CNT_W'(do_push) - CNT_W'(pop);
        head_d   = '0;
        if (count_d != '0) begin
            if (do_push && (wr_ptr_q == rd_ptr_d)) begin
                head_d = push_q.data;
            end else begin
                head_d = mem_q[rd_ptr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= push_q.data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            valid_q  <= (count_d != '0);
        end
    end

    assign c_data     = head_q;
    assign c_valid    = valid_q;
    assign fifo_count = count_q;
    assign parity_err = perr_q;
    assign frame_err  = ferr_q;
    // Depends on this cycle's pop, so it cannot be decided a cycle earlier.
    assign overflow   = push_q.valid & full & ~pop;

endmodule

// File: tb/tb_ps2_rx_fifo.sv
// Directed bench for ps2_rx_fifo: vector table of single frames plus
// hand-written timeout, overflow, glitch and reset sequences.
module tb_ps2_rx_fifo;
    import ps2_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       PS2Clk, PS2Data;
    logic [7:0] c_data;
    logic       c_valid, c_ready;
    logic       parity_err, frame_err, overflow;
    logic [2:0] fifo_count;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int perr_n = 0, ferr_n = 0, ovf_n = 0;
    int perr_cyc = 0;
    int stop_fall_cyc = 0;

    ps2_rx_fifo #(
        .SYNC_STAGES (2),
        .FILT_LEN    (2),
        .TIMEOUT_CYC (200),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .PS2Clk     (PS2Clk),
        .PS2Data    (PS2Data),
        .c_data     (c_data),
        .c_valid    (c_valid),
        .c_ready    (c_ready),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .fifo_count (fifo_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (parity_err) begin
            perr_n   <= perr_n + 1;
            perr_cyc <= cyc;
        end
        if (frame_err) ferr_n <= ferr_n + 1;
        if (overflow)  ovf_n  <= ovf_n + 1;
    end

    typedef struct {
        logic [7:0] d;
        bit         pbad;
        bit         stop;
        bit         e_valid;
        logic [7:0] e_data;
        int         e_perr;
        int         e_ferr;
    } vec_t;

    vec_t tbl [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_clk(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Sends the first nbits bits of a frame; pop_off>0 raises c_ready for the
    // single cycle that lies pop_off cycles after the stop-bit falling edge.
    task automatic send_frame(input logic [7:0] d, input bit pbad, input bit stop,
                              input int nbits, input int pop_off);
        logic bits [PS2_FRAME_BITS];
        bits[0] = 1'b0;
        for (int i = 0; i < 8; i++) bits[i+1] = d[i];
        bits[9]  = ~(^d) ^ pbad;
        bits[10] = stop;
        for (int i = 0; i < nbits; i++) begin
            PS2Data = bits[i];
            wait_clk(10);
            PS2Clk = 1'b0;
            if (i == 10) stop_fall_cyc = cyc;
            for (int k = 0; k < 20; k++) begin
                if (pop_off > 0) c_ready = (i == 10) && (cyc == stop_fall_cyc + pop_off);
                wait_clk(1);
            end
            if (pop_off > 0) c_ready = 1'b0;
            PS2Clk = 1'b1;
            wait_clk(10);
        end
        PS2Data = 1'b1;
    endtask

    task automatic pop_check(input string name, input logic [7:0] exp);
        check({name, "_valid"}, 32'(c_valid), 32'd1);
        check({name, "_data"}, 32'(c_data), 32'(exp));
        c_ready = 1'b1;
        wait_clk(1);
        c_ready = 1'b0;
    endtask

    initial begin
        int p0, f0, o0, offset, n;
        bit seen;

        tbl[0] = '{8'h1C, 1'b0, 1'b1, 1'b1, 8'h1C, 0, 0};
        tbl[1] = '{8'h1C, 1'b1, 1'b1, 1'b0, 8'h00, 1, 0};
        tbl[2] = '{8'hF0, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1};
        tbl[3] = '{8'hAA, 1'b0, 1'b1, 1'b1, 8'hAA, 0, 0};
        tbl[4] = '{8'h00, 1'b0, 1'b1, 1'b1, 8'h00, 0, 0};
        tbl[5] = '{8'hFF, 1'b0, 1'b1, 1'b1, 8'hFF, 0, 0};
        tbl[6] = '{8'h80, 1'b1, 1'b1, 1'b0, 8'h00, 1, 0};
        tbl[7] = '{8'h01, 1'b1, 1'b0, 1'b0, 8'h00, 0, 1};

        rst = 1'b1; PS2Clk = 1'b1; PS2Data = 1'b1; c_ready = 1'b0;
        wait_clk(3);
        check("rst_valid", 32'(c_valid), 32'd0);
        check("rst_data", 32'(c_data), 32'd0);
        check("rst_count", 32'(fifo_count), 32'd0);
        check("rst_flags", {29'd0, parity_err, frame_err, overflow}, 32'd0);
        rst = 1'b0;
        wait_clk(5);

        // Single-frame vectors
        for (int v = 0; v < 8; v++) begin
            p0 = perr_n; f0 = ferr_n; o0 = ovf_n;
            send_frame(tbl[v].d, tbl[v].pbad, tbl[v].stop, 11, 0);
            wait_clk(5);
            check($sformatf("v%0d_valid", v), 32'(c_valid), 32'(tbl[v].e_valid));
            check($sformatf("v%0d_data", v), 32'(c_data), 32'(tbl[v].e_data));
            check($sformatf("v%0d_count", v), 32'(fifo_count), 32'(tbl[v].e_valid));
            check($sformatf("v%0d_perr", v), 32'(perr_n - p0), 32'(tbl[v].e_perr));
            check($sformatf("v%0d_ferr", v), 32'(ferr_n - f0), 32'(tbl[v].e_ferr));
            check($sformatf("v%0d_ovf", v), 32'(ovf_n - o0), 32'd0);
            if (tbl[v].e_valid) begin
                c_ready = 1'b1;
                wait_clk(1);
                c_ready = 1'b0;
                check($sformatf("v%0d_pop_valid", v), 32'(c_valid), 32'd0);
                check($sformatf("v%0d_pop_data", v), 32'(c_data), 32'd0);
                check($sformatf("v%0d_pop_count", v), 32'(fifo_count), 32'd0);
            end
        end

        // Timeout after a truncated frame
        f0 = ferr_n;
        send_frame(8'hF0, 1'b0, 1'b1, 5, 0);
        wait_clk(100);
        check("tmo_early", 32'(ferr_n - f0), 32'd0);
        seen = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
            wait_clk(1);
            if (ferr_n != f0) seen = 1'b1;
        end
        wait_clk(3);
        check("tmo_ferr", 32'(ferr_n - f0), 32'd1);
        check("tmo_valid", 32'(c_valid), 32'd0);
        send_frame(8'hF0, 1'b0, 1'b1, 11, 0);
        wait_clk(5);
        check("tmo_next_count", 32'(fifo_count), 32'd1);
        pop_check("tmo_next", 8'hF0);

        // Fill to full, overflow on the fifth byte
        o0 = ovf_n;
        for (int b = 1; b <= 4; b++) send_frame(8'(b), 1'b0, 1'b1, 11, 0);
        wait_clk(5);
        check("fill_count", 32'(fifo_count), 32'd4);
        check("fill_ovf", 32'(ovf_n - o0), 32'd0);
        send_frame(8'h05, 1'b0, 1'b1, 11, 0);
        wait_clk(5);
        check("ovf_pulse", 32'(ovf_n - o0), 32'd1);
        check("ovf_count", 32'(fifo_count), 32'd4);
        check("ovf_head", 32'(c_data), 32'h01);

        // Flags share the push cycle: time it from a parity error, then pop there
        p0 = perr_n;
        send_frame(8'h1C, 1'b1, 1'b1, 11, 0);
        wait_clk(5);
        check("cal_perr", 32'(perr_n - p0), 32'd1);
        check("cal_count", 32'(fifo_count), 32'd4);
        offset = perr_cyc - stop_fall_cyc;
        o0 = ovf_n;
        send_frame(8'h06, 1'b0, 1'b1, 11, offset);
        wait_clk(5);
        check("pp_count", 32'(fifo_count), 32'd4);
        check("pp_ovf", 32'(ovf_n - o0), 32'd0);
        pop_check("drain0", 8'h02);
        pop_check("drain1", 8'h03);
        pop_check("drain2", 8'h04);
        pop_check("drain3", 8'h06);
        check("drain_empty", 32'(c_valid), 32'd0);

        // One-cycle clock glitch with data low must not start a frame
        f0 = ferr_n;
        PS2Data = 1'b0;
        wait_clk(5);
        PS2Clk = 1'b0;
        wait_clk(1);
        PS2Clk = 1'b1;
        wait_clk(10);
        PS2Data = 1'b1;
        wait_clk(250);
        check("glitch_ferr", 32'(ferr_n - f0), 32'd0);
        p0 = perr_n;
        send_frame(8'hAA, 1'b0, 1'b1, 11, 0);
        wait_clk(5);
        check("glitch_next_perr", 32'(perr_n - p0), 32'd0);
        pop_check("glitch_next", 8'hAA);

        // Reset mid-frame with a byte already buffered
        send_frame(8'h33, 1'b0, 1'b1, 11, 0);
        wait_clk(5);
        check("pre_rst_count", 32'(fifo_count), 32'd1);
        send_frame(8'hC3, 1'b0, 1'b1, 6, 0);
        rst = 1'b1;
        wait_clk(3);
        check("mid_rst_valid", 32'(c_valid), 32'd0);
        check("mid_rst_data", 32'(c_data), 32'd0);
        check("mid_rst_count", 32'(fifo_count), 32'd0);
        rst = 1'b0;
        f0 = ferr_n; p0 = perr_n;
        wait_clk(250);
        check("post_rst_ferr", 32'(ferr_n - f0), 32'd0);
        send_frame(8'h5A, 1'b0, 1'b1, 11, 0);
        wait_clk(5);
        check("post_rst_count", 32'(fifo_count), 32'd1);
        check("post_rst_perr", 32'(perr_n - p0), 32'd0);
        pop_check("post_rst", 8'h5A);

        n = total;
        if (n < 12) begin
            bad++;
            $display("FAIL too_few_checks: got %0d expected at least 12", n);
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
